// File: rtl/tx_pkg.sv
// Shared types and constants for the framed PAM2/PAM4 training symbol source.
// Levels are Q(8,7) codes. The top module scales them to its output format.
package tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        PAYLOAD,
        GAP
    } state_t;

    typedef logic signed [7:0] q8_t;

    // PRBS7 x^7 + x^6 + 1: the feedback bit is s[6] ^ s[5].
    localparam logic [6:0] PRBS7_SEED   = 7'h7F;
    localparam int         PRBS7_TAP_HI = 6;
    localparam int         PRBS7_TAP_LO = 5;

    localparam q8_t PAM2_LEVEL = 8'sd64;
    localparam q8_t PAM4_OUTER = 8'sd96;
    localparam q8_t PAM4_INNER = 8'sd32;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic q8_t pam2_map(input logic bit_v);
        return bit_v ? PAM2_LEVEL : -PAM2_LEVEL;
    endfunction

    // Gray-coded PAM4, first bit in the MSB.
    function automatic q8_t gray_pam4(input logic [1:0] bits);
        q8_t lvl;
        unique case (bits)
            2'b00:   lvl = -PAM4_OUTER;
            2'b01:   lvl = -PAM4_INNER;
            2'b11:   lvl = PAM4_INNER;
            default: lvl = PAM4_OUTER;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/tx_symbol_source_if.sv
// Control inputs and paced symbol outputs of tx_symbol_source, bundled as one interface.
// The master modport is the generator side. The slave modport is the consumer or driver side.
interface tx_symbol_source_if #(
    parameter int NB_OUT = 8,
    parameter int NB_LEN = 12
);

    logic                     i_en;
    logic                     i_start;
    logic                     i_continuous;
    logic                     i_pam4;
    logic [NB_LEN-1:0]        i_payload_len;
    logic signed [NB_OUT-1:0] o_sample;
    logic                     o_valid;
    logic                     o_sof;
    logic                     o_eof;
    logic                     o_busy;

    modport master (
        input  i_en, i_start, i_continuous, i_pam4, i_payload_len,
        output o_sample, o_valid, o_sof, o_eof, o_busy
    );

    modport slave (
        output i_en, i_start, i_continuous, i_pam4, i_payload_len,
        input  o_sample, o_valid, o_sof, o_eof, o_busy
    );

endinterface

// File: rtl/prbs_lfsr.sv
// PRBS7 Fibonacci LFSR. It can advance one or two steps per enable.
// o_bits = {first, second} output bits of the next two steps, valid before the advance.
module prbs_lfsr
    import tx_pkg::*;
(
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_en,
    input  logic       i_load,
    input  logic       i_adv,
    input  logic       i_two,
    output logic [1:0] o_bits
);

    logic [6:0] lfsr_q;
    logic       bit_a;
    logic       bit_b;

    // The second bit depends on taps shifted down by one.
    // The first new bit has not yet reached the taps at that point.
    assign bit_a  = lfsr_q[PRBS7_TAP_HI] ^ lfsr_q[PRBS7_TAP_LO];
    assign bit_b  = lfsr_q[PRBS7_TAP_HI-1] ^ lfsr_q[PRBS7_TAP_LO-1];
    assign o_bits = {bit_a, bit_b};

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            lfsr_q <= PRBS7_SEED;
        end else if (i_en) begin
            if (i_load) begin
                lfsr_q <= PRBS7_SEED;
            end else if (i_adv) begin
                lfsr_q <= i_two ? {lfsr_q[4:0], bit_a, bit_b} : {lfsr_q[5:0], bit_a};
            end
        end
    end

endmodule

// File: rtl/tx_symbol_source.sv
// Framed training symbol generator: alternating preamble, PRBS7 payload, then a zero gap.
// The generator emits one registered symbol strobe every SYM_DIV enabled clocks.
module tx_symbol_source
    import tx_pkg::*;
#(
    parameter int NB_OUT       = 8,
    parameter int NBF_OUT      = 7,
    parameter int SYM_DIV      = 4,
    parameter int PREAMBLE_LEN = 32,
    parameter int GAP_LEN      = 8,
    parameter int NB_LEN       = 12
) (
    input  logic               i_clock,
    input  logic               i_reset,
    tx_symbol_source_if.master bus
);

    localparam int PW    = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
    localparam int PRE_W = $clog2(PREAMBLE_LEN + 1);
    localparam int GAP_W = $clog2(GAP_LEN + 2);
    localparam int CW    = max_int(NB_LEN, max_int(PRE_W, GAP_W));

    typedef logic signed [NB_OUT-1:0] sample_t;

    function automatic sample_t scale(input q8_t q);
        sample_t w;
        w = sample_t'(q);
        return w <<< (NBF_OUT - 7);
    endfunction

    state_t            state_q, state_d;
    logic [PW-1:0]     pace_q, pace_d;
    logic [CW-1:0]     sym_q, sym_d;
    logic [NB_LEN-1:0] len_q, len_d;
    logic              pam4_q, pam4_d;
    sample_t           sample_q, sample_d;
    logic              valid_q, valid_d;
    logic              sof_q, sof_d;
    logic              eof_q, eof_d;
    logic              busy_q, busy_d;

    logic [CW-1:0] limit;
    logic          tick;
    logic          period_end;
    logic          last_sym;
    logic          gap_next;
    logic          frame_end;
    logic          start_req;
    logic          lfsr_load;
    logic          lfsr_adv;
    logic [1:0]    lfsr_bits;
    q8_t           pre_lvl;

    prbs_lfsr u_prbs (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_en    (bus.i_en),
        .i_load  (lfsr_load),
        .i_adv   (lfsr_adv),
        .i_two   (pam4_q),
        .o_bits  (lfsr_bits)
    );

    assign tick       = (pace_q == '0);
    assign period_end = (pace_q == PW'(SYM_DIV - 1));
    assign last_sym   = (sym_q == limit - 1'b1);
    assign pre_lvl    = pam4_q ? PAM4_OUTER : PAM2_LEVEL;

    always_comb begin
        unique case (state_q)
            PREAMBLE: limit = CW'(PREAMBLE_LEN);
            PAYLOAD:  limit = CW'(len_q);
            GAP:      limit = CW'(GAP_LEN);
            default:  limit = '0;
        endcase
    end

    // NOTE: every *_d and strobe gets a default before any branch. Otherwise the
    // incomplete if/case paths below would infer latches.
    always_comb begin
        state_d   = state_q;
        pace_d    = pace_q;
        sym_d     = sym_q;
        len_d     = len_q;
        pam4_d    = pam4_q;
        sample_d  = sample_q;
        valid_d   = 1'b0;
        sof_d     = 1'b0;
        eof_d     = 1'b0;
        gap_next  = 1'b0;
        frame_end = 1'b0;
        start_req = 1'b0;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;

        if (bus.i_en) begin
            if (state_q == IDLE) begin
                sample_d  = '0;
                start_req = bus.i_start;
            end else begin
                pace_d = period_end ? '0 : pace_q + 1'b1;

                if (tick) begin
                    valid_d = 1'b1;
                    unique case (state_q)
                        PREAMBLE: begin
                            sample_d = scale(sym_q[0] ? -pre_lvl : pre_lvl);
                            sof_d    = (sym_q == '0);
                            eof_d    = last_sym && (len_q == '0);
                        end
                        PAYLOAD: begin
                            lfsr_adv = 1'b1;
                            sample_d = pam4_q ? scale(gray_pam4(lfsr_bits))
                                              : scale(pam2_map(lfsr_bits[1]));
                            eof_d    = last_sym;
                        end
                        default: sample_d = '0;
                    endcase
                end

                // State changes only at the end of a symbol period.
                // This keeps the strobe spacing uniform across state boundaries.
                if (period_end) begin
                    if (!last_sym) begin
                        sym_d = sym_q + 1'b1;
                    end else begin
                        sym_d = '0;
                        unique case (state_q)
                            PREAMBLE: begin
                                if (len_q != '0) state_d = PAYLOAD;
                                else             gap_next = 1'b1;
                            end
                            PAYLOAD: gap_next  = 1'b1;
                            default: frame_end = 1'b1;
                        endcase
                    end
                end

                if (gap_next) begin
                    if (GAP_LEN != 0) state_d = GAP;
                    else              frame_end = 1'b1;
                end

                if (frame_end) begin
                    if (bus.i_continuous) begin
                        start_req = 1'b1;
                    end else begin
                        state_d = IDLE;
                        if (!tick) sample_d = '0;
                    end
                end
            end

            if (start_req) begin
                state_d   = PREAMBLE;
                pace_d    = '0;
                sym_d     = '0;
                len_d     = bus.i_payload_len;
                pam4_d    = bus.i_pam4;
                lfsr_load = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    // NOTE: register updates use non-blocking assignment.
    // Every flop then samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= IDLE;
            pace_q   <= '0;
            sym_q    <= '0;
            len_q    <= '0;
            pam4_q   <= 1'b0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            sof_q    <= 1'b0;
            eof_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pace_q   <= pace_d;
            sym_q    <= sym_d;
            len_q    <= len_d;
            pam4_q   <= pam4_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            sof_q    <= sof_d;
            eof_q    <= eof_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.o_sample = sample_q;
    assign bus.o_valid  = valid_q;
    assign bus.o_sof    = sof_q;
    assign bus.o_eof    = eof_q;
    assign bus.o_busy   = busy_q;

endmodule
